ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xF4 (enable data reporting) or 0xFF (reset), to the mouse over the shared open-drain ps2c/ps2d lines. It sits beside the PS/2 receive path inside the mouse unit and owns the lines only while a transmission is in progress. While `tx_idle` is low, the receive path ignores bus activity.

## Interface

**Parameters**
- `RTS_CYCLES`, default 5000: clocks the host holds ps2c low to request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum clocks to wait for any single device clock falling edge (15 ms at 50 MHz).

**Ports**
- `clk` — input, 1: system clock. One clock domain only.
- `reset` — input, 1: synchronous, active-high.
- `ps2c` — inout, 1: PS/2 clock line. Open-drain: the block drives 0 or releases to Z, never drives 1.
- `ps2d` — inout, 1: PS/2 data line. Open-drain, same rule.
- `wr_ps2` — input, 1: one-cycle write strobe. Sampled only in IDLE.
- `din` — input, 8: command byte. Captured on an accepted `wr_ps2`.
- `tx_idle` — output, 1: 1 in IDLE, otherwise 0.
- `tx_done_tick` — output, 1: one-cycle pulse when a frame completes and the device acknowledges.
- `tx_err_tick` — output, 1: one-cycle pulse on timeout or a missing acknowledge.

## Operation

**Clock filter**
- ps2c is passed through an 8-sample shift register.
- Filtered level changes to 1 only when all 8 samples are 1, and to 0 only when all 8 samples are 0. Otherwise it holds its previous value.
- `fall_edge` pulses for one cycle when the filtered level goes 1 to 0.

**Frame construction**
- On `wr_ps2` in IDLE, latch the 9-bit shift register {parity, din}.
- parity = ~^din (odd parity).
- Bits go out LSB first.

**State machine**
- **IDLE:** both lines released. On `wr_ps2`, load the shift register, clear the counter, go to RTS.
- **RTS:** drive ps2c low. After `RTS_CYCLES` clocks, go to START.
- **START:** release ps2c and drive ps2d low (start bit). On `fall_edge`, go to DATA with bit count n=8.
- **DATA:** ps2d = low when shift[0]==0, else released. On each `fall_edge`, shift right. When n reaches 0 (9 bits sent, including parity), go to STOP; otherwise decrement n.
- **STOP:** release ps2d. On `fall_edge`, go to ACK.
- **ACK:** on `fall_edge`, sample filtered ps2d. If 0, pulse `tx_done_tick`; if 1, pulse `tx_err_tick`. Then return to IDLE.

**Timeout and write rules**
- In START, DATA, STOP and ACK, a watchdog counter reloads on every `fall_edge`.
- If the watchdog reaches `TIMEOUT_CYCLES` with no edge, release both lines, pulse `tx_err_tick`, and return to IDLE.
- `wr_ps2` outside IDLE is ignored. The frame in progress is not altered.

## Timing

**Reset values** (reset wins over every other event in the same cycle):
- state = IDLE
- ps2c and ps2d released (Z)
- `tx_idle` = 1
- `tx_done_tick` = 0, `tx_err_tick` = 0
- shift register, bit count and counters = 0

**Reset mid-frame:** lines are released at the next clock edge, and no tick is emitted.

**Cycle-level timing:**
- `tx_idle` falls the cycle after `wr_ps2` is accepted.
- ps2c goes low that same cycle and is held for exactly `RTS_CYCLES` cycles.
- `fall_edge` lags the raw ps2c falling edge by 8–9 clocks because of the filter.
- Data changes one cycle after `fall_edge`. The device samples on its rising edge, tens of microseconds later.
- `tx_done_tick` / `tx_err_tick` are asserted in the cycle the state returns to IDLE. `tx_idle` rises in the following cycle.
- A new `wr_ps2` is accepted from the first cycle `tx_idle`=1.
- All outputs are registered.

**Boundary cases:**
- A glitch on ps2c shorter than 8 clocks produces no edge.
- A `fall_edge` and a watchdog expiry in the same cycle: the edge wins.

## Test plan

- **Command 0xF4:** write 0xF4; the device model clocks at 12.5 kHz and pulls ps2d low on the 11th edge. Required:
  - ps2c low for 5000 cycles.
  - ps2d bits seen by the device: start 0, then 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - `tx_done_tick` high for one cycle; `tx_idle` returns to 1.
- **Parity check:** write 0x00, then 0xFF. Required: parity bit 1 for both.
- **Missing acknowledge:** the device leaves ps2d high on the ack edge. Required: `tx_err_tick` pulse, no `tx_done_tick`, both lines Z.
- **Timeout:** the device stops clocking after 4 edges. Required: `tx_err_tick` pulse exactly `TIMEOUT_CYCLES` cycles after the last `fall_edge`, then IDLE with lines released.
- **Write ignored and glitch rejected:**
  - `wr_ps2` with 0xAA during DATA of a 0xF4 frame: the frame still carries 0xF4.
  - A 5-cycle low glitch on ps2c: no bit shift occurs.
- **Reset mid-frame:** assert `reset` during DATA. Required on the next cycle: lines Z, `tx_idle`=1, no tick. A following 0xF4 frame then completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity, stop, ack check.
// Drives the open-drain ps2c/ps2d lines only low; otherwise releases them to Z.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2c,
    inout  wire        ps2d,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

    state_t             state;
    logic [8:0]         shift;
    logic [3:0]         n;
    logic [CNT_W-1:0]   cnt;
    logic               c_oe;
    logic               d_oe;
    logic [7:0]         c_filt;
    logic [7:0]         d_filt;
    logic               c_lvl;
    logic               d_lvl;
    logic               c_lvl_next;
    logic               d_lvl_next;
    logic               fall_edge;

    assign ps2c = c_oe ? 1'b0 : 1'bz;
    assign ps2d = d_oe ? 1'b0 : 1'bz;

    // Filtered level only moves once 8 consecutive samples agree.
    always_comb begin
        c_lvl_next = c_lvl;
        d_lvl_next = d_lvl;
        if (&c_filt)
            c_lvl_next = 1'b1;
        else if (~|c_filt)
            c_lvl_next = 1'b0;
        if (&d_filt)
            d_lvl_next = 1'b1;
        else if (~|d_filt)
            d_lvl_next = 1'b0;
        fall_edge = c_lvl & ~c_lvl_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift        <= '0;
            n            <= '0;
            cnt          <= '0;
            c_oe         <= 1'b0;
            d_oe         <= 1'b0;
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
            c_filt       <= '1;
            d_filt       <= '1;
            c_lvl        <= 1'b1;
            d_lvl        <= 1'b1;
        end else begin
            c_filt       <= {ps2c, c_filt[7:1]};
            d_filt       <= {ps2d, d_filt[7:1]};
            c_lvl        <= c_lvl_next;
            d_lvl        <= d_lvl_next;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
            case (state)
                IDLE: begin
                    tx_idle <= 1'b1;
                    c_oe    <= 1'b0;
                    d_oe    <= 1'b0;
                    // tx_idle gates acceptance so a new write starts only after it rises
                    if (wr_ps2 && tx_idle) begin
                        shift   <= {~^din, din};
                        cnt     <= '0;
                        c_oe    <= 1'b1;
                        tx_idle <= 1'b0;
                        state   <= RTS;
                    end
                end
                RTS: begin
                    if (cnt == CNT_W'(RTS_CYCLES - 1)) begin
                        cnt   <= '0;
                        c_oe  <= 1'b0;
                        d_oe  <= 1'b1;
                        state <= START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Device-clocked phases: an edge reloads the watchdog and wins over expiry.
                    if (fall_edge) begin
                        cnt <= '0;
                        case (state)
                            START: begin
                                n     <= 4'd8;
                                d_oe  <= ~shift[0];
                                state <= DATA;
                            end
                            DATA: begin
                                shift <= {1'b0, shift[8:1]};
                                if (n == 4'd0) begin
                                    d_oe  <= 1'b0;
                                    state <= STOP;
                                end else begin
                                    n    <= n - 4'd1;
                                    d_oe <= ~shift[1];
                                end
                            end
                            STOP: begin
                                state <= ACK;
                            end
                            ACK: begin
                                if (!d_lvl)
                                    tx_done_tick <= 1'b1;
                                else
                                    tx_err_tick  <= 1'b1;
                                c_oe  <= 1'b0;
                                d_oe  <= 1'b0;
                                state <= IDLE;
                            end
                            default: begin
                                c_oe  <= 1'b0;
                                d_oe  <= 1'b0;
                                state <= IDLE;
                            end
                        endcase
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt         <= '0;
                        c_oe        <= 1'b0;
                        d_oe        <= 1'b0;
                        tx_err_tick <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the sampled bits, tick pulses and line states are compared with hand-computed values.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int RTS  = 50;
    localparam int TMO  = 400;
    localparam int HALF = 40;
    localparam int GAP  = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;
    logic       dev_c_low;
    logic       dev_d_low;
    wire        ps2c;
    wire        ps2d;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic prev_tick = 1'b0;
    logic idle_at_tick = 1'b1;
    logic idle_after_tick = 1'b0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err_tick  (tx_err_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt++;
        if (tx_err_tick) err_cnt++;
        if (prev_tick) idle_after_tick = tx_idle;
        if (tx_done_tick || tx_err_tick) idle_at_tick = tx_idle;
        prev_tick = tx_done_tick | tx_err_tick;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_cmd(input logic [7:0] d);
        @(negedge clk);
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'h00;
    endtask

    task automatic measure_rts(input string tag);
        int cnt = 0;
        while (ps2c === 1'b0 && cnt < 4 * RTS) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_rts_len"}, cnt, RTS);
    endtask

    // Device model: samples ps2d before the first clock (start bit) and at each rising edge.
    task automatic dev_frame(input int n_pulses, input bit ack, input bit glitch,
                             input bit late_wr, output logic [10:0] seen);
        seen = '0;
        repeat (GAP) @(negedge clk);
        seen[0] = ps2d;
        for (int i = 1; i <= n_pulses; i++) begin
            @(negedge clk);
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (i <= 10) seen[i] = ps2d;
            if (ack && i == 11) dev_d_low = 1'b1;
            if (i == 12) dev_d_low = 1'b0;
            if (glitch && i == 3) begin
                repeat (10) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (HALF - 16) @(negedge clk);
            end else if (late_wr && i == 4) begin
                repeat (10) @(negedge clk);
                din    = 8'hAA;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (HALF - 12) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
        end
    endtask

    task automatic full_frame(input string tag, input logic [7:0] d, input bit ack,
                              input bit glitch, input bit late_wr, input logic [10:0] exp_bits);
        logic [10:0] seen;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        write_cmd(d);
        chk({tag, "_idle_low"}, tx_idle, 1'b0);
        measure_rts(tag);
        dev_frame(12, ack, glitch, late_wr, seen);
        repeat (3) @(negedge clk);
        chk({tag, "_bits"}, seen, exp_bits);
        chk({tag, "_done"}, done_cnt - d0, ack ? 1 : 0);
        chk({tag, "_err"}, err_cnt - e0, ack ? 0 : 1);
        chk({tag, "_idle_at_tick"}, idle_at_tick, 1'b0);
        chk({tag, "_idle_after_tick"}, idle_after_tick, 1'b1);
        chk({tag, "_ps2c_rel"}, ps2c, 1'b1);
        chk({tag, "_ps2d_rel"}, ps2d, 1'b1);
        chk({tag, "_idle_end"}, tx_idle, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [10:0] seen;
        int d0, e0, cnt;
        reset     = 1'b1;
        wr_ps2    = 1'b0;
        din       = 8'h00;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_idle", tx_idle, 1'b1);
        chk("rst_done", tx_done_tick, 1'b0);
        chk("rst_err", tx_err_tick, 1'b0);
        chk("rst_ps2c", ps2c, 1'b1);
        chk("rst_ps2d", ps2d, 1'b1);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // {stop, parity, data, start}: 0xF4 has five ones -> parity 0
        full_frame("f4", 8'hF4, 1'b1, 1'b0, 1'b0, 11'h5E8);
        full_frame("x00_noack", 8'h00, 1'b0, 1'b0, 1'b0, 11'h600);
        full_frame("xff", 8'hFF, 1'b1, 1'b0, 1'b0, 11'h7FE);
        full_frame("f4_glitch_wr", 8'hF4, 1'b1, 1'b1, 1'b1, 11'h5E8);

        // Device stops after four clocks: error must land 8 filter + 1 register + TMO clocks later.
        d0 = done_cnt;
        e0 = err_cnt;
        write_cmd(8'hF4);
        measure_rts("tmo");
        dev_frame(3, 1'b0, 1'b0, 1'b0, seen);
        @(negedge clk);
        dev_c_low = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == HALF) dev_c_low = 1'b0;
        end while (!tx_err_tick && cnt < TMO + 100);
        chk("tmo_latency", cnt, 9 + TMO);
        repeat (3) @(negedge clk);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_done", done_cnt - d0, 0);
        chk("tmo_ps2c_rel", ps2c, 1'b1);
        chk("tmo_ps2d_rel", ps2d, 1'b1);
        chk("tmo_idle", tx_idle, 1'b1);

        // Reset while bit1 (a 0 of 0xF4) is on the line.
        d0 = done_cnt;
        e0 = err_cnt;
        write_cmd(8'hF4);
        measure_rts("rstmid");
        dev_frame(2, 1'b0, 1'b0, 1'b0, seen);
        chk("rstmid_pre_ps2d", ps2d, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_ps2c", ps2c, 1'b1);
        chk("rstmid_ps2d", ps2d, 1'b1);
        chk("rstmid_idle", tx_idle, 1'b1);
        chk("rstmid_ticks", (done_cnt - d0) + (err_cnt - e0), 0);
        repeat (5) @(negedge clk);
        full_frame("f4_after_rst", 8'hF4, 1'b1, 1'b0, 1'b0, 11'h5E8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
